// File: rtl/uart_pkg.sv
// Shared constants, FSM state types and small helpers for the parametrised UART.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4,
        RX_DONE   = 3'd5
    } rx_state_t;

    // Ceiling log2 for elaboration-time widths; callers pass values >= 2.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Data words are zero-extended to 9 bits, which leaves the XOR unchanged.
    function automatic logic parity_of(input logic [8:0] data, input int mode);
        return (mode == PARITY_ODD) ? ~(^data) : (^data);
    endfunction

endpackage

// File: rtl/uart_param_txrx_rx_core.sv
// UART receiver: two-flop input synchronizer, mid-bit sampling FSM and registered result/error outputs.
module uart_param_txrx_rx_core
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int CLK_PER_BIT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err
);

    localparam int CNT_W = clog2(CLK_PER_BIT);
    localparam int BIT_W = clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_PER_BIT / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_ZERO  = BIT_W'(0);
    localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic HAS_PARITY = (PARITY_MODE != PARITY_NONE) ? 1'b1 : 1'b0;

    logic [1:0]           sync_r;
    logic                 rx_sync_s;
    rx_state_t            state_r, state_s;
    logic [CNT_W-1:0]     cnt_r, cnt_s;
    logic [BIT_W-1:0]     bit_r, bit_s;
    logic [DATA_BITS-1:0] shift_r, shift_s;
    logic                 par_bit_r, par_bit_s;
    logic                 stop_err_r, stop_err_s;
    logic [DATA_BITS-1:0] data_r, data_s;
    logic                 valid_r, valid_s;
    logic                 perr_r, perr_s;
    logic                 ferr_r, ferr_s;

    assign rx_sync_s = sync_r[1];

    // Idle-high synchronizer for the asynchronous pin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], rx};
        end
    end

    // Receive state, sampling counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= RX_IDLE;
            cnt_r      <= CNT_ZERO;
            bit_r      <= BIT_ZERO;
            shift_r    <= {DATA_BITS{1'b0}};
            par_bit_r  <= 1'b0;
            stop_err_r <= 1'b0;
            data_r     <= {DATA_BITS{1'b0}};
            valid_r    <= 1'b0;
            perr_r     <= 1'b0;
            ferr_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            bit_r      <= bit_s;
            shift_r    <= shift_s;
            par_bit_r  <= par_bit_s;
            stop_err_r <= stop_err_s;
            data_r     <= data_s;
            valid_r    <= valid_s;
            perr_r     <= perr_s;
            ferr_r     <= ferr_s;
        end
    end

    // Next-state logic; after the half-bit start check every sample lands on a bit centre.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        bit_s      = bit_r;
        shift_s    = shift_r;
        par_bit_s  = par_bit_r;
        stop_err_s = stop_err_r;
        data_s     = data_r;
        valid_s    = 1'b0;
        perr_s     = perr_r;
        ferr_s     = ferr_r;
        case (state_r)
            RX_IDLE: begin
                cnt_s = CNT_ZERO;
                bit_s = BIT_ZERO;
                if (!rx_sync_s) begin
                    state_s = RX_START;
                end else begin
                    state_s = RX_IDLE;
                end
            end
            RX_START: begin
                if (cnt_r == HALF_LAST) begin
                    cnt_s = CNT_ZERO;
                    if (rx_sync_s) begin
                        state_s = RX_IDLE;
                    end else begin
                        state_s = RX_DATA;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            RX_DATA: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_s   = CNT_ZERO;
                    shift_s = {rx_sync_s, shift_r[DATA_BITS-1:1]};
                    if (bit_r == BIT_LAST) begin
                        state_s = HAS_PARITY ? RX_PARITY : RX_STOP;
                    end else begin
                        bit_s = bit_r + BIT_ONE;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            RX_PARITY: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_s     = CNT_ZERO;
                    par_bit_s = rx_sync_s;
                    state_s   = RX_STOP;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            RX_STOP: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_s      = CNT_ZERO;
                    stop_err_s = ~rx_sync_s;
                    state_s    = RX_DONE;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            RX_DONE: begin
                valid_s = 1'b1;
                data_s  = shift_r;
                perr_s  = HAS_PARITY && (par_bit_r != parity_of(9'(shift_r), PARITY_MODE));
                ferr_s  = stop_err_r;
                state_s = RX_IDLE;
            end
            default: begin
                state_s = RX_IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    assign rx_data       = data_r;
    assign rx_valid      = valid_r;
    assign rx_parity_err = perr_r;
    assign rx_frame_err  = ferr_r;

endmodule

// File: rtl/uart_param_txrx.sv
// Parametrised full-duplex UART: valid/ready transmitter FSM here, receiver in uart_param_txrx_rx_core.
module uart_param_txrx
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1,
    parameter int CLK_PER_BIT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 Tx,
    input  logic                 Rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err
);

    localparam int CNT_W = clog2(CLK_PER_BIT);
    localparam int BIT_W = clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_ZERO  = BIT_W'(0);
    localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic STOP_LAST  = (STOP_BITS == 2) ? 1'b1 : 1'b0;
    localparam logic HAS_PARITY = (PARITY_MODE != PARITY_NONE) ? 1'b1 : 1'b0;

    tx_state_t            tx_state_r, tx_state_s;
    logic [CNT_W-1:0]     tx_cnt_r, tx_cnt_s;
    logic [BIT_W-1:0]     tx_bit_r, tx_bit_s;
    logic                 tx_stop_r, tx_stop_s;
    logic [DATA_BITS-1:0] tx_shift_r, tx_shift_s;
    logic                 tx_par_r, tx_par_s;
    logic                 tx_line_r, tx_line_s;
    logic                 tx_ready_r, tx_ready_s;

    // Transmit state, counters and the registered line/ready outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_r <= TX_IDLE;
            tx_cnt_r   <= CNT_ZERO;
            tx_bit_r   <= BIT_ZERO;
            tx_stop_r  <= 1'b0;
            tx_shift_r <= {DATA_BITS{1'b0}};
            tx_par_r   <= 1'b0;
            tx_line_r  <= 1'b1;
            tx_ready_r <= 1'b1;
        end else begin
            tx_state_r <= tx_state_s;
            tx_cnt_r   <= tx_cnt_s;
            tx_bit_r   <= tx_bit_s;
            tx_stop_r  <= tx_stop_s;
            tx_shift_r <= tx_shift_s;
            tx_par_r   <= tx_par_s;
            tx_line_r  <= tx_line_s;
            tx_ready_r <= tx_ready_s;
        end
    end

    // Next-state logic; the line value for each bit is registered on the edge that starts it.
    always_comb begin
        tx_state_s = tx_state_r;
        tx_cnt_s   = tx_cnt_r;
        tx_bit_s   = tx_bit_r;
        tx_stop_s  = tx_stop_r;
        tx_shift_s = tx_shift_r;
        tx_par_s   = tx_par_r;
        tx_line_s  = tx_line_r;
        tx_ready_s = tx_ready_r;
        case (tx_state_r)
            TX_IDLE: begin
                tx_cnt_s = CNT_ZERO;
                if (tx_valid && tx_ready_r) begin
                    tx_state_s = TX_START;
                    tx_shift_s = tx_data;
                    tx_par_s   = parity_of(9'(tx_data), PARITY_MODE);
                    tx_line_s  = 1'b0;
                    tx_ready_s = 1'b0;
                end else begin
                    tx_line_s  = 1'b1;
                    tx_ready_s = 1'b1;
                end
            end
            TX_START: begin
                if (tx_cnt_r == CNT_LAST) begin
                    tx_state_s = TX_DATA;
                    tx_cnt_s   = CNT_ZERO;
                    tx_bit_s   = BIT_ZERO;
                    tx_line_s  = tx_shift_r[0];
                    tx_shift_s = {1'b0, tx_shift_r[DATA_BITS-1:1]};
                end else begin
                    tx_cnt_s = tx_cnt_r + CNT_ONE;
                end
            end
            TX_DATA: begin
                if (tx_cnt_r == CNT_LAST) begin
                    tx_cnt_s = CNT_ZERO;
                    if (tx_bit_r == BIT_LAST) begin
                        if (HAS_PARITY) begin
                            tx_state_s = TX_PARITY;
                            tx_line_s  = tx_par_r;
                        end else begin
                            tx_state_s = TX_STOP;
                            tx_line_s  = 1'b1;
                            tx_stop_s  = 1'b0;
                        end
                    end else begin
                        tx_bit_s   = tx_bit_r + BIT_ONE;
                        tx_line_s  = tx_shift_r[0];
                        tx_shift_s = {1'b0, tx_shift_r[DATA_BITS-1:1]};
                    end
                end else begin
                    tx_cnt_s = tx_cnt_r + CNT_ONE;
                end
            end
            TX_PARITY: begin
                if (tx_cnt_r == CNT_LAST) begin
                    tx_state_s = TX_STOP;
                    tx_cnt_s   = CNT_ZERO;
                    tx_line_s  = 1'b1;
                    tx_stop_s  = 1'b0;
                end else begin
                    tx_cnt_s = tx_cnt_r + CNT_ONE;
                end
            end
            TX_STOP: begin
                if (tx_cnt_r == CNT_LAST) begin
                    tx_cnt_s = CNT_ZERO;
                    if (tx_stop_r == STOP_LAST) begin
                        tx_state_s = TX_IDLE;
                        tx_ready_s = 1'b1;
                    end else begin
                        tx_stop_s = 1'b1;
                    end
                end else begin
                    tx_cnt_s = tx_cnt_r + CNT_ONE;
                end
            end
            default: begin
                tx_state_s = TX_IDLE;
                tx_cnt_s   = CNT_ZERO;
                tx_line_s  = 1'b1;
                tx_ready_s = 1'b1;
            end
        endcase
    end

    assign Tx       = tx_line_r;
    assign tx_ready = tx_ready_r;

    uart_param_txrx_rx_core #(
        .DATA_BITS   (DATA_BITS),
        .PARITY_MODE (PARITY_MODE),
        .CLK_PER_BIT (CLK_PER_BIT)
    ) u_rx_core (
        .clk           (clk),
        .rst           (rst),
        .rx            (Rx),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_parity_err (rx_parity_err),
        .rx_frame_err  (rx_frame_err)
    );

endmodule
